banked_unified_buffer: RTL and testbench
========================================

// Module: banked_unified_buffer
// PURPOSE
//   Next-generation unified buffer between host FIFOs and the systolic compute array. Stores BUFFER_SIZE words.
//   Accepts one request at a time over a valid/ready handshake. FIFO requests move one FIFO_DATA_WIDTH section
//   of one word. Compute requests move all NUM_COMPUTE_LANES lanes over BEATS cycles, WORDS_PER_BEAT words per
//   cycle, with out-of-range detection and a done/error completion pulse.
// PARAMETERS
//   BUFFER_SIZE        1024  words in buffer; must be a power of two
//   BUFFER_WORD_SIZE   16    bits per word
//   FIFO_DATA_WIDTH    8     bits per FIFO transfer; must divide BUFFER_WORD_SIZE
//   COMPUTE_DATA_WIDTH 4     bits per compute lane; must divide BUFFER_WORD_SIZE
//   ARRAY_SIZE         8     systolic array dimension
//   NUM_COMPUTE_LANES  ARRAY_SIZE*ARRAY_SIZE  compute lanes
//   WORDS_PER_BEAT     4     words moved per compute beat; must divide TOTAL_WORDS
//   ADDRESS_SIZE       $clog2(BUFFER_SIZE)
//   Derived (localparam, not overridable):
//     ITEMS=WORD/COMPUTE=4; TOTAL_WORDS=LANES/ITEMS=16; BEATS=TOTAL_WORDS/WORDS_PER_BEAT=4;
//     SECTIONS=WORD/FIFO=2; SEC_W=max(1,$clog2(SECTIONS))
// PORTS
//   clk          in   1         clock, rising edge
//   rst_n        in   1         asynchronous, active-low reset
//   req_valid    in   1         request present
//   req_ready    out  1         buffer can accept a request (high only in IDLE)
//   req_write    in   1         1=write buffer, 0=read buffer
//   req_compute  in   1         1=compute transfer, 0=FIFO transfer
//   req_section  in   SEC_W     FIFO section; section s = word bits [s*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH]
//   req_address  in   ADDRESS_SIZE  word address (compute: base of TOTAL_WORDS-word block)
//   fifo_in      in   FIFO_DATA_WIDTH  FIFO write data
//   fifo_out     out  FIFO_DATA_WIDTH  FIFO read data, valid when done=1
//   compute_in   in   [LANES] x COMPUTE_DATA_WIDTH  compute write lanes
//   compute_out  out  [LANES] x COMPUTE_DATA_WIDTH  compute read lanes, all valid when done=1
//   done         out  1         one-cycle completion pulse
//   error        out  1         one-cycle pulse, coincident with done, on rejected request
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, req_ready=1, done=0, error=0, fifo_out=0, compute_out all 0.
//     Memory is not cleared. Beats already committed remain; remaining beats are never written.
//   Handshake: accept in cycle T when req_valid&&req_ready. At acceptance, latch all req_* fields,
//     fifo_in and the entire compute_in array. Input changes after T have no effect.
//     req_valid while busy is ignored (no queueing).
//   FSM: IDLE -accept-> XFER (beat=0); XFER -last beat-> DONE; DONE -> IDLE.
//     Range error at accept -> DONE directly, with error=1.
//   Range check: compute request with req_address+TOTAL_WORDS > BUFFER_SIZE is an error.
//     Error means no memory write and no compute_out change. FIFO requests never error.
//   FIFO op: one XFER cycle (T+1). Write updates only the selected section; other bits are preserved.
//     Read registers fifo_out. done=1 at T+2; req_ready=1 at T+3.
//   Compute op: XFER beat b (0..BEATS-1) at cycle T+1+b.
//     Beat b touches words A+b*WORDS_PER_BEAT+w, for w=0..WORDS_PER_BEAT-1.
//     Word k, nibble j <-> lane k*ITEMS+j; lane 0 is the LSBs of word A.
//     Read beats update only their own lanes of compute_out.
//     done=1 at T+1+BEATS; compute_out holds until the next compute read completes a beat.
//   Error op: done=error=1 at T+1, req_ready=1 at T+2.
//   fifo_out holds its value until the next FIFO read.
//   done and error are registered outputs, 0 in all other cycles.
// TESTING
//   1 Assert rst_n=0 mid-idle -> req_ready=1, done=0, error=0, fifo_out=0, all compute_out=0.
//   2 FIFO wr addr 5 sec0=0xAB, then sec1=0xCD -> FIFO rd sec1=0xCD, sec0=0xAB.
//     Each op: done 2 cycles after accept.
//   3 Compute wr lane i=i%16 at addr 100 -> done at T+5; compute rd addr 100 returns lane i=i%16.
//     FIFO rd addr 100 sec0 = 0x10, sec1 = 0x32.
//   4 Compute wr at addr 1010 (1010+16>1024) -> done=error=1 at T+1; prior contents of 1010..1023 unchanged.
//   5 Hold req_valid through busy cycles and change compute_in at T+2 -> second request not accepted
//     until req_ready=1; stored data equals compute_in sampled at T.
//   6 Compute wr addr 200, assert rst_n=0 after beats 0-1 commit -> words 200-207 new, 208-215 old.
//     After reset release, req_ready=1.

Source files
------------

// File: rtl/banked_unified_buffer.sv
// Unified buffer between the host FIFOs and the systolic compute array.
// One request is in flight at a time. A FIFO request moves one section of one
// word in a single transfer cycle. A compute request moves a whole block of
// TOTAL_WORDS words over BEATS cycles. A compute block that would run past the
// end of the buffer is rejected and finishes with done and error both high.
module banked_unified_buffer #(
  parameter int BUFFER_SIZE        = 1024,
  parameter int BUFFER_WORD_SIZE   = 16,
  parameter int FIFO_DATA_WIDTH    = 8,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ARRAY_SIZE         = 8,
  parameter int NUM_COMPUTE_LANES  = ARRAY_SIZE * ARRAY_SIZE,
  parameter int WORDS_PER_BEAT     = 4,
  parameter int ADDRESS_SIZE       = $clog2(BUFFER_SIZE),
  localparam int ITEMS       = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
  localparam int TOTAL_WORDS = NUM_COMPUTE_LANES / ITEMS,
  localparam int BEATS       = TOTAL_WORDS / WORDS_PER_BEAT,
  localparam int SECTIONS    = BUFFER_WORD_SIZE / FIFO_DATA_WIDTH,
  localparam int SEC_W       = (SECTIONS > 1) ? $clog2(SECTIONS) : 1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                req_valid,
  output logic                                                req_ready,
  input  logic                                                req_write,
  input  logic                                                req_compute,
  input  logic [SEC_W-1:0]                                    req_section,
  input  logic [ADDRESS_SIZE-1:0]                             req_address,
  input  logic [FIFO_DATA_WIDTH-1:0]                          fifo_in,
  output logic [FIFO_DATA_WIDTH-1:0]                          fifo_out,
  input  logic [NUM_COMPUTE_LANES-1:0][COMPUTE_DATA_WIDTH-1:0] compute_in,
  output logic [NUM_COMPUTE_LANES-1:0][COMPUTE_DATA_WIDTH-1:0] compute_out,
  output logic                                                done,
  output logic                                                error
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WIDX_W = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam int BIT_W  = $clog2(BUFFER_WORD_SIZE);

  localparam logic [ADDRESS_SIZE:0] SPAN      = (ADDRESS_SIZE + 1)'(TOTAL_WORDS);
  localparam logic [ADDRESS_SIZE:0] LIMIT     = (ADDRESS_SIZE + 1)'(BUFFER_SIZE);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t state_q, state_d;

  // Word storage. Lane k*ITEMS+j lives in nibble j of word k of a block, so
  // the flat lane vector and a vector of TOTAL_WORDS words share one layout.
  logic [BUFFER_WORD_SIZE-1:0] mem [BUFFER_SIZE];

  // Request fields captured at acceptance
  logic                                         write_q;
  logic                                         compute_q;
  logic [SEC_W-1:0]                             section_q;
  logic [ADDRESS_SIZE-1:0]                      address_q;
  logic [FIFO_DATA_WIDTH-1:0]                   fifo_in_q;
  logic [TOTAL_WORDS-1:0][BUFFER_WORD_SIZE-1:0] compute_in_q;

  logic [BEAT_W-1:0]                            beat_q;
  logic [FIFO_DATA_WIDTH-1:0]                   fifo_out_q;
  logic [TOTAL_WORDS-1:0][BUFFER_WORD_SIZE-1:0] compute_out_q;
  logic                                         done_q;
  logic                                         error_q;

  logic                    accept;
  logic                    range_err;
  logic                    xfer;
  logic                    last_beat;
  logic [ADDRESS_SIZE:0]   req_end;
  logic [BIT_W-1:0]        sec_lsb;
  logic [ADDRESS_SIZE-1:0] beat_addr [WORDS_PER_BEAT];
  logic [WIDX_W-1:0]       beat_widx [WORDS_PER_BEAT];

  // Request decode: acceptance, range check, and the words the current beat touches
  always_comb begin
    accept    = req_valid && (state_q == IDLE);
    req_end   = {1'b0, req_address} + SPAN;
    range_err = req_compute && (req_end > LIMIT);
    xfer      = (state_q == XFER);
    last_beat = !compute_q || (beat_q == LAST_BEAT);
    sec_lsb   = BIT_W'(int'(section_q) * FIFO_DATA_WIDTH);
    for (int w = 0; w < WORDS_PER_BEAT; w++) begin
      beat_widx[w] = WIDX_W'(int'(beat_q) * WORDS_PER_BEAT + w);
      beat_addr[w] = address_q + ADDRESS_SIZE'(int'(beat_q) * WORDS_PER_BEAT + w);
    end
  end

  // Next-state logic: a rejected request skips the transfer phase entirely
  always_comb begin
    // NOTE: state_d gets its hold value before the case so every path assigns
    // it; a path that left it unassigned would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = range_err ? DONE : XFER;
      XFER:    if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control, captured request, completion flags and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      write_q       <= 1'b0;
      compute_q     <= 1'b0;
      section_q     <= '0;
      address_q     <= '0;
      fifo_in_q     <= '0;
      compute_in_q  <= '0;
      fifo_out_q    <= '0;
      compute_out_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      done_q  <= (xfer && last_beat) || (accept && range_err);
      error_q <= accept && range_err;

      if (accept) begin
        write_q      <= req_write;
        compute_q    <= req_compute;
        section_q    <= req_section;
        address_q    <= req_address;
        fifo_in_q    <= fifo_in;
        compute_in_q <= compute_in;
        beat_q       <= '0;
      end else if (xfer) begin
        beat_q <= beat_q + BEAT_W'(1);
      end

      // Reads update only what they fetched; everything else holds
      if (xfer && !write_q) begin
        if (compute_q) begin
          for (int w = 0; w < WORDS_PER_BEAT; w++) begin
            compute_out_q[beat_widx[w]] <= mem[beat_addr[w]];
          end
        end else begin
          fifo_out_q <= mem[address_q][sec_lsb +: FIFO_DATA_WIDTH];
        end
      end
    end
  end

  // Memory writes: a whole beat of words, or a single section of one word
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately left out of reset; clearing it
    // would need a port per word. Writes only happen in XFER, which reset
    // leaves immediately, so an interrupted block keeps its committed beats.
    if (xfer && write_q) begin
      if (compute_q) begin
        for (int w = 0; w < WORDS_PER_BEAT; w++) begin
          mem[beat_addr[w]] <= compute_in_q[beat_widx[w]];
        end
      end else begin
        mem[address_q][sec_lsb +: FIFO_DATA_WIDTH] <= fifo_in_q;
      end
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign fifo_out    = fifo_out_q;
  assign compute_out = compute_out_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_banked_unified_buffer.sv
// Directed bench for banked_unified_buffer with hand-computed expectations.
module tb_banked_unified_buffer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic             req_compute;
  logic [0:0]       req_section;
  logic [9:0]       req_address;
  logic [7:0]       fifo_in;
  logic [7:0]       fifo_out;
  logic [63:0][3:0] compute_in;
  logic [63:0][3:0] compute_out;
  logic             done;
  logic             error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  banked_unified_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_compute (req_compute),
    .req_section (req_section),
    .req_address (req_address),
    .fifo_in     (fifo_in),
    .fifo_out    (fifo_out),
    .compute_in  (compute_in),
    .compute_out (compute_out),
    .done        (done),
    .error       (error)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Lane i carries (i*mul + add) mod 16
  function automatic logic [255:0] pat(input int mul, input int add);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[i*4 +: 4] = 4'((i * mul + add) & 15);
    return v;
  endfunction

  // One request: drive at cycle T, scramble the inputs afterwards, wait for done
  task automatic do_req(input string tag, input bit wr, input bit cmp, input bit sec,
                        input int addr, input logic [7:0] fin, input logic [255:0] cin,
                        input int exp_lat, input bit exp_err);
    int lat;
    @(negedge clk);
    check({tag, " ready"}, req_ready, 1'b1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_compute = cmp;
    req_section = sec;
    req_address = 10'(addr);
    fifo_in     = fin;
    compute_in  = cin;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid   = 1'b0;
        req_write   = ~wr;
        req_compute = ~cmp;
        req_section = ~sec;
        req_address = 10'(addr) ^ 10'h155;
        fifo_in     = ~fin;
        compute_in  = ~cin;
      end
    end while (!done && lat < 20);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " error"}, error, exp_err);
    @(negedge clk);
    check({tag, " ready after"}, req_ready, 1'b1);
    check({tag, " done pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [255:0] pa, pb, pc, pd;
    logic [12:0]  done_mask;
    pa = pat(1, 0);
    pb = pat(3, 1);
    pc = pat(5, 7);
    pd = pat(7, 2);

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_compute = 1'b0;
    req_section = 1'b0;
    req_address = '0;
    fifo_in     = '0;
    compute_in  = '0;
    repeat (2) @(negedge clk);
    check("por ready", req_ready, 1'b1);
    check("por done", done, 1'b0);
    check("por error", error, 1'b0);
    rst_n = 1'b1;

    // FIFO section writes preserve the other section
    do_req("fifo wr 5 s0", 1, 0, 0, 5, 8'hAB, '0, 2, 0);
    do_req("fifo wr 5 s1", 1, 0, 1, 5, 8'hCD, '0, 2, 0);
    do_req("fifo rd 5 s1", 0, 0, 1, 5, 8'h00, '0, 2, 0);
    check("fifo rd 5 s1 data", fifo_out, 8'hCD);
    do_req("fifo rd 5 s0", 0, 0, 0, 5, 8'h00, '0, 2, 0);
    check("fifo rd 5 s0 data", fifo_out, 8'hAB);

    // Compute block write/read and its word layout
    do_req("cmp wr 100", 1, 1, 0, 100, 8'h00, pa, 5, 0);
    do_req("cmp rd 100", 0, 1, 0, 100, 8'h00, '0, 5, 0);
    check("cmp rd 100 data", compute_out, pa);
    do_req("fifo rd 100 s0", 0, 0, 0, 100, 8'h00, '0, 2, 0);
    check("fifo rd 100 s0 data", fifo_out, 8'h10);
    do_req("fifo rd 100 s1", 0, 0, 1, 100, 8'h00, '0, 2, 0);
    check("fifo rd 100 s1 data", fifo_out, 8'h32);
    check("compute_out holds", compute_out, pa);

    // Reset while idle clears outputs but not memory
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("idle rst ready", req_ready, 1'b1);
    check("idle rst done", done, 1'b0);
    check("idle rst error", error, 1'b0);
    check("idle rst fifo_out", fifo_out, 8'h00);
    check("idle rst compute_out", compute_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req("fifo rd 5 post rst", 0, 0, 0, 5, 8'h00, '0, 2, 0);
    check("fifo rd 5 post rst data", fifo_out, 8'hAB);

    // Range boundary: 1008 fits exactly, 1010 overruns
    do_req("cmp wr 1008", 1, 1, 0, 1008, 8'h00, pb, 5, 0);
    do_req("cmp wr 1010 err", 1, 1, 0, 1010, 8'h00, pc, 1, 1);
    do_req("cmp rd 1008", 0, 1, 0, 1008, 8'h00, '0, 5, 0);
    check("cmp rd 1008 data", compute_out, pb);
    do_req("cmp rd 1010 err", 0, 1, 0, 1010, 8'h00, '0, 1, 1);
    check("compute_out after err", compute_out, pb);
    do_req("fifo rd 1023 s1", 0, 0, 1, 1023, 8'h00, '0, 2, 0);
    check("fifo rd 1023 s1 data", fifo_out, 8'hEB);

    // Held req_valid while busy; inputs change at T+2
    @(negedge clk);
    check("hold ready T", req_ready, 1'b1);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_compute = 1'b1;
    req_address = 10'd300;
    compute_in  = pc;
    done_mask   = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) done_mask[c] = 1'b1;
      if (c == 2) begin
        compute_in  = pd;
        req_address = 10'd400;
      end
      if (c == 3) check("hold busy ready", req_ready, 1'b0);
      if (c == 6) check("hold ready again", req_ready, 1'b1);
      if (c == 7) req_valid = 1'b0;
    end
    check("hold done cycles", done_mask, (13'd1 << 5) | (13'd1 << 11));
    do_req("cmp rd 300", 0, 1, 0, 300, 8'h00, '0, 5, 0);
    check("cmp rd 300 data", compute_out, pc);
    do_req("cmp rd 400", 0, 1, 0, 400, 8'h00, '0, 5, 0);
    check("cmp rd 400 data", compute_out, pd);

    // Reset after beats 0 and 1 of a block write have committed
    do_req("cmp wr 200 old", 1, 1, 0, 200, 8'h00, pa, 5, 0);
    @(negedge clk);
    check("abort ready T", req_ready, 1'b1);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_compute = 1'b1;
    req_address = 10'd200;
    compute_in  = pb;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort rst ready", req_ready, 1'b1);
    check("abort rst done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort release ready", req_ready, 1'b1);
    do_req("cmp rd 200", 0, 1, 0, 200, 8'h00, '0, 5, 0);
    check("cmp rd 200 data", compute_out, {pa[255:128], pb[127:0]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
